// File: rtl/spi_xfer_buf.sv
// spi_xfer_buf: byte-buffering transfer sequencer between a CPU register
// interface and spi_master. Software fills a TX FIFO; the sequencer launches
// one spi_master transfer per byte and captures each received byte into an
// RX FIFO that software drains. Only one transfer is ever outstanding.
module spi_xfer_buf #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          rx_discard,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          tx_full,
  output logic [AW:0]   tx_level,
  output logic          wr_err,
  input  logic          tx_flush,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rx_empty,
  output logic [AW:0]   rx_level,
  output logic          rd_err,
  input  logic          rx_flush,
  output logic          busy,
  output logic          tx_start,
  output logic [7:0]    txdata,
  input  logic          tr_flag,
  input  logic [7:0]    rxdata
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT} state_t;

  state_t        state;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wptr;
  logic [AW-1:0] tx_rptr;
  logic [AW:0]   tx_lvl;
  logic          tx_empty;
  logic          tx_push;
  logic          tx_pop;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wptr;
  logic [AW-1:0] rx_rptr;
  logic [AW:0]   rx_lvl;
  logic          rx_full;
  logic          rx_push;
  logic          rx_pop;
  logic [AW-1:0] rx_rptr_nxt;
  logic [AW:0]   rx_lvl_nxt;
  logic [7:0]    rd_data_nxt;

  logic          launch;

  assign tx_empty = (tx_lvl == '0);
  assign tx_full  = (tx_lvl == FULL_LVL);
  assign tx_level = tx_lvl;
  assign rx_empty = (rx_lvl == '0);
  assign rx_full  = (rx_lvl == FULL_LVL);
  assign rx_level = rx_lvl;
  assign busy     = (state != S_IDLE);

  // Launch only when a byte is queued and the RX side can hold its reply;
  // a flush in the same cycle wins over the sequencer pop.
  assign launch  = (state == S_IDLE) && en && !tx_empty &&
                   (rx_discard || !rx_full) && !tx_flush;
  assign tx_pop  = launch;
  assign tx_push = wr_en && (!tx_full || tx_pop);

  assign rx_pop  = rd_en && !rx_empty;
  assign rx_push = (state == S_WAIT) && tr_flag && !rx_discard &&
                   (!rx_full || rx_pop);

  // Next RX head: the byte being pushed when it lands on the new head slot,
  // otherwise the stored entry; hold the last value once the FIFO drains.
  always_comb begin
    rx_rptr_nxt = rx_pop ? rx_rptr + AW'(1) : rx_rptr;
    rx_lvl_nxt  = rx_lvl;
    if (rx_push && !rx_pop)
      rx_lvl_nxt = rx_lvl + (AW+1)'(1);
    else if (!rx_push && rx_pop)
      rx_lvl_nxt = rx_lvl - (AW+1)'(1);
    rd_data_nxt = rd_data;
    if (rx_push && (rx_rptr_nxt == rx_wptr))
      rd_data_nxt = rxdata;
    else if (rx_lvl_nxt != '0)
      rd_data_nxt = rx_mem[rx_rptr_nxt];
  end

  // TX FIFO storage (data only, no reset).
  always_ff @(posedge clk) begin
    if (tx_push && !tx_flush)
      tx_mem[tx_wptr] <= wr_data;
  end

  // TX FIFO pointers, level and overflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wptr <= '0;
      tx_rptr <= '0;
      tx_lvl  <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_err <= wr_en && tx_full && !tx_pop;
      if (tx_flush) begin
        tx_wptr <= '0;
        tx_rptr <= '0;
        tx_lvl  <= '0;
      end else begin
        if (tx_push)
          tx_wptr <= tx_wptr + AW'(1);
        if (tx_pop)
          tx_rptr <= tx_rptr + AW'(1);
        if (tx_push && !tx_pop)
          tx_lvl <= tx_lvl + (AW+1)'(1);
        else if (!tx_push && tx_pop)
          tx_lvl <= tx_lvl - (AW+1)'(1);
      end
    end
  end

  // RX FIFO storage (data only, no reset).
  always_ff @(posedge clk) begin
    if (rx_push && !rx_flush)
      rx_mem[rx_wptr] <= rxdata;
  end

  // RX FIFO pointers, level, registered head and underflow pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr <= '0;
      rx_rptr <= '0;
      rx_lvl  <= '0;
      rd_err  <= 1'b0;
      rd_data <= 8'h00;
    end else begin
      rd_err <= rd_en && rx_empty;
      if (rx_flush) begin
        rx_wptr <= '0;
        rx_rptr <= '0;
        rx_lvl  <= '0;
      end else begin
        if (rx_push)
          rx_wptr <= rx_wptr + AW'(1);
        rx_rptr <= rx_rptr_nxt;
        rx_lvl  <= rx_lvl_nxt;
        rd_data <= rd_data_nxt;
      end
    end
  end

  // Transfer sequencer: IDLE pops and loads txdata, START pulses tx_start,
  // WAIT holds until spi_master reports the end of the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx_start <= 1'b0;
      txdata   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          tx_start <= 1'b0;
          if (launch) begin
            txdata   <= tx_mem[tx_rptr];
            tx_start <= 1'b1;
            state    <= S_START;
          end
        end
        S_START: begin
          tx_start <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          tx_start <= 1'b0;
          if (tr_flag)
            state <= S_IDLE;
        end
        default: begin
          tx_start <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_xfer_buf.sv
// Directed testbench for spi_xfer_buf with a behavioural SPI slave that
// answers each launched byte with its complement 20 clocks later.
module tb_spi_xfer_buf;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          rx_discard = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          tx_full;
  logic [AW:0]   tx_level;
  logic          wr_err;
  logic          tx_flush = 1'b0;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic [AW:0]   rx_level;
  logic          rd_err;
  logic          rx_flush = 1'b0;
  logic          busy;
  logic          tx_start;
  logic [7:0]    txdata;
  logic          tr_flag;
  logic [7:0]    rxdata = 8'h00;

  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;

  int         scnt = 0;
  logic [7:0] sdata = 8'h00;
  logic       slave_flag = 1'b0;

  assign tr_flag = slave_flag;

  spi_xfer_buf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .rx_discard(rx_discard),
    .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_level(tx_level), .wr_err(wr_err), .tx_flush(tx_flush),
    .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty),
    .rx_level(rx_level), .rd_err(rd_err), .rx_flush(rx_flush),
    .busy(busy), .tx_start(tx_start), .txdata(txdata),
    .tr_flag(tr_flag), .rxdata(rxdata)
  );

  always #5 clk = ~clk;

  // Behavioural slave: reply with the complement 20 clocks after tx_start.
  always @(posedge clk) begin
    if (tx_start) begin
      scnt  <= 20;
      sdata <= txdata ^ 8'hFF;
    end else if (scnt != 0) begin
      scnt <= scnt - 1;
    end
    slave_flag <= (scnt == 1) && !tx_start;
    if (scnt == 1)
      rxdata <= sdata;
  end

  // Count launch pulses mid-cycle.
  always @(negedge clk) begin
    if (tx_start)
      start_cnt <= start_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    vectors++;
    if ({tx_full, rx_empty, wr_err, rd_err, busy, tx_start} !== 6'b010000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 010000",
               {tx_full, rx_empty, wr_err, rd_err, busy, tx_start});
    end
    vectors++;
    if ({tx_level, rx_level} !== '0) begin
      miscompares++;
      $display("FAIL reset_levels: got tx=%0d rx=%0d expected 0 0", tx_level, rx_level);
    end
    vectors++;
    if ({txdata, rd_data} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_data: got txdata=%h rd_data=%h expected 00 00", txdata, rd_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    en = 1'b1;
    rx_discard = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h66;
    tick();
    wr_en = 1'b0;
    vectors++;
    if ({tx_start, tx_level} !== {1'b0, 4'd1}) begin
      miscompares++;
      $display("FAIL single_queued: got start=%b lvl=%0d expected 0 1", tx_start, tx_level);
    end
    tick();
    vectors++;
    if ({tx_start, txdata, busy, tx_level} !== {1'b1, 8'h66, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL single_launch: got start=%b txdata=%h busy=%b lvl=%0d expected 1 66 1 0",
               tx_start, txdata, busy, tx_level);
    end
    tick();
    vectors++;
    if (tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL single_pulse_width: got %b expected 0", tx_start);
    end
    n = 0;
    while (rx_level == 0 && n < 60) begin
      tick();
      n++;
    end
    vectors++;
    if ({rx_level, rd_data, busy} !== {4'd1, 8'h99, 1'b0}) begin
      miscompares++;
      $display("FAIL single_rx: got lvl=%0d rd_data=%h busy=%b expected 1 99 0",
               rx_level, rd_data, busy);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if ({rx_empty, rx_level, rd_err} !== {1'b1, 4'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_read: got empty=%b lvl=%0d rd_err=%b expected 1 0 0",
               rx_empty, rx_level, rd_err);
    end
  endtask

  task automatic test_burst();
    int k;
    int starts;
    int last_tr;
    logic [7:0] exp;
    en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    vectors++;
    if ({tx_full, tx_level} !== {1'b1, 4'd8}) begin
      miscompares++;
      $display("FAIL burst_full: got full=%b lvl=%0d expected 1 8", tx_full, tx_level);
    end
    wr_en = 1'b1;
    wr_data = 8'h09;
    tick();
    wr_en = 1'b0;
    vectors++;
    if ({wr_err, tx_level} !== {1'b1, 4'd8}) begin
      miscompares++;
      $display("FAIL burst_overflow: got wr_err=%b lvl=%0d expected 1 8", wr_err, tx_level);
    end
    tick();
    vectors++;
    if (wr_err !== 1'b0) begin
      miscompares++;
      $display("FAIL burst_wr_err_pulse: got %b expected 0", wr_err);
    end
    en = 1'b1;
    k = 0;
    starts = 0;
    last_tr = -1;
    while ((rx_level != 4'd8 || busy) && k < 400) begin
      tick();
      k++;
      if (tr_flag)
        last_tr = k;
      if (tx_start) begin
        starts++;
        if (last_tr >= 0) begin
          vectors++;
          if (k - last_tr != 2) begin
            miscompares++;
            $display("FAIL burst_gap: got %0d cycles expected 2", k - last_tr);
          end
        end
      end
    end
    vectors++;
    if (starts != 8 || rx_level !== 4'd8) begin
      miscompares++;
      $display("FAIL burst_count: got starts=%0d rx_lvl=%0d expected 8 8", starts, rx_level);
    end
    for (int i = 0; i < 8; i++) begin
      exp = 8'(i + 1) ^ 8'hFF;
      vectors++;
      if (rd_data !== exp) begin
        miscompares++;
        $display("FAIL burst_rd_%0d: got %h expected %h", i, rd_data, exp);
      end
      rd_en = 1'b1;
      tick();
    end
    rd_en = 1'b0;
    vectors++;
    if (rx_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL burst_drained: got empty=%b expected 1", rx_empty);
    end
  endtask

  task automatic test_backpressure();
    int base;
    int n;
    en = 1'b0;
    rx_discard = 1'b0;
    base = start_cnt;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h10 + i);
      tick();
    end
    wr_en = 1'b0;
    en = 1'b1;
    for (int j = 0; j < 2; j++) begin
      n = 0;
      tick();
      while (tx_full && n < 100) begin
        tick();
        n++;
      end
      wr_en = 1'b1;
      wr_data = 8'(8'h18 + j);
      tick();
      wr_en = 1'b0;
    end
    n = 0;
    while (!(rx_level == 4'd8 && !busy) && n < 400) begin
      tick();
      n++;
    end
    for (int i = 0; i < 50; i++)
      tick();
    vectors++;
    if ((start_cnt - base) != 8 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_stall: got starts=%0d busy=%b expected 8 0", start_cnt - base, busy);
    end
    vectors++;
    if ({tx_level, rx_level} !== {4'd2, 4'd8}) begin
      miscompares++;
      $display("FAIL bp_levels: got tx=%0d rx=%0d expected 2 8", tx_level, rx_level);
    end
    vectors++;
    if (rd_data !== 8'hEF) begin
      miscompares++;
      $display("FAIL bp_head: got %h expected ef", rd_data);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    for (int i = 0; i < 50; i++)
      tick();
    vectors++;
    if ((start_cnt - base) != 9 || {tx_level, rx_level, busy} !== {4'd1, 4'd8, 1'b0}) begin
      miscompares++;
      $display("FAIL bp_resume: got starts=%0d tx=%0d rx=%0d busy=%b expected 9 1 8 0",
               start_cnt - base, tx_level, rx_level, busy);
    end
    en = 1'b0;
    tx_flush = 1'b1;
    rx_flush = 1'b1;
    tick();
    tx_flush = 1'b0;
    rx_flush = 1'b0;
    vectors++;
    if ({tx_level, rx_level} !== '0) begin
      miscompares++;
      $display("FAIL bp_flush: got tx=%0d rx=%0d expected 0 0", tx_level, rx_level);
    end
  endtask

  task automatic test_discard();
    int base;
    int n;
    logic saw_rx;
    en = 1'b1;
    rx_discard = 1'b1;
    base = start_cnt;
    saw_rx = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'hA0 + i);
      tick();
    end
    wr_en = 1'b0;
    n = 0;
    while (!((start_cnt - base) == 3 && !busy) && n < 200) begin
      tick();
      if (!rx_empty)
        saw_rx = 1'b1;
      n++;
    end
    vectors++;
    if ((start_cnt - base) != 3 || saw_rx !== 1'b0 || rx_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL discard: got starts=%0d saw_rx=%b empty=%b expected 3 0 1",
               start_cnt - base, saw_rx, rx_empty);
    end
    rx_discard = 1'b0;
    wr_en = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (rx_level == 0 && n < 60) begin
      tick();
      n++;
    end
    vectors++;
    if ({rx_level, rd_data} !== {4'd1, 8'hA5}) begin
      miscompares++;
      $display("FAIL discard_off_rx: got lvl=%0d rd_data=%h expected 1 a5", rx_level, rd_data);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    vectors++;
    if ({rd_err, rd_data, rx_empty} !== {1'b1, 8'hA5, 1'b1}) begin
      miscompares++;
      $display("FAIL underflow: got rd_err=%b rd_data=%h empty=%b expected 1 a5 1",
               rd_err, rd_data, rx_empty);
    end
    tick();
    vectors++;
    if (rd_err !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_err_pulse: got %b expected 0", rd_err);
    end
  endtask

  task automatic test_flush();
    int base;
    int n;
    en = 1'b0;
    base = start_cnt;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      wr_data = 8'(8'h30 + i);
      tick();
    end
    wr_en = 1'b0;
    en = 1'b1;
    n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++)
      tick();
    tx_flush = 1'b1;
    tick();
    tx_flush = 1'b0;
    vectors++;
    if ({tx_level, busy} !== {4'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_tx: got lvl=%0d busy=%b expected 0 1", tx_level, busy);
    end
    n = 0;
    while (rx_level == 0 && n < 60) begin
      tick();
      n++;
    end
    vectors++;
    if ({rx_level, rd_data} !== {4'd1, 8'hCF}) begin
      miscompares++;
      $display("FAIL flush_inflight: got lvl=%0d rd_data=%h expected 1 cf", rx_level, rd_data);
    end
    for (int i = 0; i < 60; i++)
      tick();
    vectors++;
    if ((start_cnt - base) != 1) begin
      miscompares++;
      $display("FAIL flush_no_launch: got starts=%0d expected 1", start_cnt - base);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_rst_mid();
    int n;
    logic saw_tr;
    en = 1'b1;
    wr_en = 1'b1;
    wr_data = 8'h40;
    tick();
    wr_en = 1'b0;
    n = 0;
    while (!tx_start && n < 20) begin
      tick();
      n++;
    end
    for (int i = 0; i < 5; i++)
      tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({busy, tx_start, rx_empty, tx_full, wr_err, rd_err} !== 6'b001000) begin
      miscompares++;
      $display("FAIL rst_mid_flags: got %b expected 001000",
               {busy, tx_start, rx_empty, tx_full, wr_err, rd_err});
    end
    vectors++;
    if ({txdata, rd_data, tx_level, rx_level} !== '0) begin
      miscompares++;
      $display("FAIL rst_mid_data: got txdata=%h rd_data=%h tx=%0d rx=%0d expected 00 00 0 0",
               txdata, rd_data, tx_level, rx_level);
    end
    saw_tr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (tr_flag)
        saw_tr = 1'b1;
    end
    vectors++;
    if (saw_tr !== 1'b1 || rx_level !== 4'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_late_flag: got tr_seen=%b rx=%0d busy=%b expected 1 0 0",
               saw_tr, rx_level, busy);
    end
  endtask

  task automatic test_wrap();
    int sent;
    int rcv;
    int k;
    int max_rx;
    int max_tx;
    logic [7:0] exp;
    en = 1'b1;
    rx_discard = 1'b0;
    sent = 0;
    rcv = 0;
    k = 0;
    max_rx = 0;
    max_tx = 0;
    while (rcv < 20 && k < 1500) begin
      wr_en = (sent < 20) && (tx_level == 0) && !busy;
      if (wr_en) begin
        wr_data = 8'(8'h80 + sent);
        sent++;
      end
      rd_en = !rx_empty;
      if (!rx_empty) begin
        exp = 8'(8'h80 + rcv) ^ 8'hFF;
        vectors++;
        if (rd_data !== exp) begin
          miscompares++;
          $display("FAIL wrap_rd_%0d: got %h expected %h", rcv, rd_data, exp);
        end
        rcv++;
      end
      tick();
      if (int'(rx_level) > max_rx)
        max_rx = int'(rx_level);
      if (int'(tx_level) > max_tx)
        max_tx = int'(tx_level);
      k++;
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    vectors++;
    if (rcv != 20 || max_rx > 1 || max_tx > 1) begin
      miscompares++;
      $display("FAIL wrap_stream: got rcv=%0d max_rx=%0d max_tx=%0d expected 20 <=1 <=1",
               rcv, max_rx, max_tx);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_discard();
    test_flush();
    test_rst_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
